// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// start, mthi and mtlo are sampled on a rising edge only while busy=0; busy=1 means the request is ignored.
interface mdu_hilo_if;
  logic        start;
  logic [1:0]  MDOp;
  logic        mthi;
  logic        mtlo;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_state;

  modport master (
    output start, MDOp, mthi, mtlo, A, B,
    input  busy, HI, LO, dbg_state
  );

  modport slave (
    input  start, MDOp, mthi, mtlo, A, B,
    output busy, HI, LO, dbg_state
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning HI/LO; a fixed-latency counter
// gates a single commit of the latched operation's result into HI/LO.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_hilo_if.slave  bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   a_q, b_q;
  logic [1:0]    op_q;
  logic [31:0]   hi_q, lo_q;
  logic          launch, commit;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    launch  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          launch  = 1'b1;
          state_n = RUN;
          cnt_n   = bus.MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          commit  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Result datapath works from the latched operands only.
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, mag_a, mag_b, uq, ur, sq, sr;
  logic [31:0] res_hi, res_lo;
  logic        res_ok;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    // Divisor forced non-zero so the divider never sees zero; the commit is suppressed instead.
    div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    mag_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b  = div_b[31] ? (~div_b + 32'd1) : div_b;
    uq     = mag_a / mag_b;
    ur     = mag_a % mag_b;
    sq     = (a_q[31] ^ div_b[31]) ? (~uq + 32'd1) : uq;
    sr     = a_q[31] ? (~ur + 32'd1) : ur;
    res_ok = 1'b1;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      2'b00: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      2'b01: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      2'b10: begin res_hi = sr; res_lo = sq; res_ok = (b_q != 32'd0); end
      default: begin
        res_hi = a_q % div_b;
        res_lo = a_q / div_b;
        res_ok = (b_q != 32'd0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (launch) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= bus.MDOp;
      end
      if (commit && res_ok) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state == IDLE && !bus.start) begin
        if (bus.mthi) hi_q <= bus.A;
        if (bus.mtlo) lo_q <= bus.A;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed bench for mdu_hilo: a driver queues expected HI/LO and
// busy length per launch, a negedge monitor checks them when busy falls.
module tb_mdu_hilo;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  int          len_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
      2'b01: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b10: if (b != 0) begin
        q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0];
      end
      default: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
    endcase
  endtask

  // Monitor
  logic        prev_busy = 1'b0;
  int          run_len = 0;
  logic [63:0] e_val;
  int          e_len;
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      run_len   = 0;
    end else begin
      if (bus.busy) run_len++;
      else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got completion want none");
        end else begin
          e_val = exp_q.pop_front();
          e_len = len_q.pop_front();
          chk("hilo", {bus.HI, bus.LO}, e_val);
          chk("busy_len", 64'(run_len), 64'(e_len));
        end
        run_len = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic ml);
    @(negedge clk);
    bus.start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b; bus.mthi = mh; bus.mtlo = ml;
    model_op(op, a, b);
    exp_q.push_back({m_hi, m_lo});
    len_q.push_back(op[1] ? DC : MC);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'(0));
  endtask

  task automatic mt_write(input logic hen, input logic len, input logic [31:0] a);
    @(negedge clk);
    bus.mthi = hen; bus.mtlo = len; bus.A = a;
    if (hen) m_hi = a;
    if (len) m_lo = a;
    @(posedge clk);
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("mt_write", {bus.HI, bus.LO}, {m_hi, m_lo});
  endtask

  task automatic no_relaunch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_relaunch", 64'(bus.busy), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          r;
    bus.start = 1'b0; bus.MDOp = 2'b00; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_hilo", {bus.HI, bus.LO}, 64'(0));
    reset = 1'b0;

    // Asynchronous reset mid-cycle
    mt_write(1'b1, 1'b1, 32'h0000_0055);
    @(posedge clk);
    #3 reset = 1'b1;
    m_hi = '0; m_lo = '0;
    #1;
    chk("async_reset_busy", 64'(bus.busy), 64'(0));
    chk("async_reset_hilo", {bus.HI, bus.LO}, 64'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    mt_write(1'b1, 1'b0, 32'h1234_5678);

    // Directed operations
    launch(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0); wait_idle();
    launch(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0); wait_idle();
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0); wait_idle();
    launch(2'b11, 32'd7, 32'd2, 1'b0, 1'b0); wait_idle();
    mt_write(1'b1, 1'b1, 32'hAAAA_0000);
    mt_write(1'b0, 1'b1, 32'h0000_BBBB);
    launch(2'b11, 32'd1234, 32'd0, 1'b0, 1'b0); wait_idle();
    launch(2'b10, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0); wait_idle();
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0); wait_idle();

    // Requests while busy are ignored
    launch(2'b00, 32'd3, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.MDOp = 2'b10; bus.A = 32'h9999_9999; bus.B = 32'd1; bus.mthi = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
    wait_idle();
    no_relaunch();

    // start together with mtlo: mtlo dropped
    launch(2'b01, 32'd5, 32'd6, 1'b0, 1'b1); wait_idle();

    // start held for several cycles launches once
    @(negedge clk);
    bus.start = 1'b1; bus.MDOp = 2'b00; bus.A = 32'hFFFF_FFFD; bus.B = 32'd7;
    model_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    exp_q.push_back({m_hi, m_lo});
    len_q.push_back(MC);
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    no_relaunch();

    // Reset aborts a running divide
    launch(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete(); len_q.delete();
    m_hi = '0; m_lo = '0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_hilo", {bus.HI, bus.LO}, 64'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    launch(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0); wait_idle();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      if (r == 4) begin
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        op = 2'(r);
        a  = $urandom;
        b  = $urandom;
        if ($urandom_range(0, 7) == 0) b = 32'd0;
        else if (op[1] && $urandom_range(0, 1) == 1) b = $urandom_range(1, 20);
        if (op[1] && $urandom_range(0, 1) == 1) b = -b;
        launch(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wait_idle();
      end
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit that owns the HI and LO registers. It produces the HILO value consumed by the ALU result-select path.
- Sits in the EX stage beside the ALU. It takes operands RD1/RD2 (after forwarding) and reports busy so the hazard unit can stall following MDU/HILO-reading instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch operation selected by MDOp, 1-cycle pulse
- MDOp  input  2  00 mult, 01 multu, 10 div, 11 divu
- mthi  input  1  write A to HI
- mtlo  input  1  write A to LO
- A  input  32  operand rs
- B  input  32  operand rt
- busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, state=IDLE. Reset is asynchronous and active-high, and takes effect immediately at any time.
- States:
  - IDLE: on a clk edge with start=1, latch A, B and MDOp. Load counter with MULT_CYCLES (MDOp[1]=0) or DIV_CYCLES (MDOp[1]=1). Go to RUN, so busy=1 from the next cycle.
  - RUN: counter decrements each edge. On the edge where counter==1, write HI/LO from the latched operands and return to IDLE, so busy=0.
  - busy is high for exactly N cycles. New HI/LO values are visible in the same cycle busy falls.
- mult: signed 64-bit product, HI=[63:32], LO=[31:0].
- multu: unsigned 64-bit product, HI=[63:32], LO=[31:0].
- div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0 for div/divu): full latency, busy behaves normally, HI and LO are left unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO always reflect the last committed value. Intermediate results are never exposed.
- mthi/mtlo apply only in IDLE: HI<=A or LO<=A at the edge. Both may be asserted together.
- Ignored inputs:
  - start, mthi and mtlo are ignored while busy=1. The hazard unit guarantees this never happens, and the unit must still not corrupt state.
  - If start and mthi/mtlo are asserted together in IDLE, start wins and the mt write is dropped.
- start must not be re-sampled: a start held high for several cycles launches only one operation. A new launch requires the unit to be back in IDLE and start to be high on that edge.
- Reset during RUN aborts the operation. busy=0, HI=LO=0, and no commit occurs.
- Hazard unit stall condition: (start | busy) together with an MDU or mfhi/mflo instruction in ID. The unit does not generate the stall itself.

Test Plan:
- Reset: assert reset mid-cycle -> busy, HI and LO go to 0 immediately without a clock edge. Deassert, then mthi with A=0x12345678 -> HI=0x12345678 after one edge, LO=0.
- mult vs multu:
  - mult with A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: A=7, B=2 -> LO=3, HI=1.
- Divide by zero: preload HI=0xAAAA0000 and LO=0x0000BBBB via mthi/mtlo, then divu with B=0 -> busy 10 cycles, HI and LO unchanged.
- Ignored inputs during RUN: start mult 3*4, then pulse start with div and pulse mthi while busy -> single 5-cycle busy window, HI=0, LO=12.
  - start and mtlo together in IDLE -> mult result committed, mtlo dropped.
- Abort: start div 100/7, assert reset on cycle 4 of busy -> busy=0 immediately and HI=LO=0. After release, a new multu 0x10000*0x10000 -> HI=1, LO=0.
